stage_2_pipe: RTL and testbench

- Registered, handshaked successor of the combinational Q15/boolean interval-update plus one-round renormalization stage.
- Owns the encoder state (range, low, s) internally. Accepts one symbol per cycle and exports the bytes released by renormalization, including the carry bit, to the downstream carry-propagation/packing stage.
- Adds valid/ready flow control, a synchronous re-init for frame start, and a parametrised minimum-probability constant.

---
 rtl/ec_pkg.sv | 28 ++
 rtl/leading_zero.sv | 28 ++
 rtl/stage_2_pipe.sv | 178 +++++++++++++++++
 tb/tb_stage_2_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// ============================================================================
// Module      : ec_pkg
// Description : Shared widths and constants for the range-coder encode stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ec_pkg;

  localparam int RANGE_WIDTH    = 16;
  localparam int LOW_WIDTH      = 24;
  localparam int D_SIZE         = 5;
  localparam int BYTE_WIDTH     = 9;
  localparam int EC_MIN_PROB    = 4;
  localparam int FULL_LOW_WIDTH = LOW_WIDTH + 8;

  localparam logic [RANGE_WIDTH-1:0] RANGE_RESET = RANGE_WIDTH'(32'h8000);

  // Number of byte words released by one renormalization round
  typedef enum logic [1:0] {
    EMIT_NONE = 2'd0,
    EMIT_ONE  = 2'd1,
    EMIT_TWO  = 2'd2
  } emit_e;

endpackage

`default_nettype wire

// File: rtl/leading_zero.sv
// ============================================================================
// Module      : leading_zero
// Description : Leading-zero count of a WIDTH-bit word; all-zero input yields WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leading_zero #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     i_value,
  output logic [OUT_WIDTH-1:0] o_zeros
);

  // Scan upward so the most significant set bit is the last to win
  always_comb begin
    o_zeros = OUT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_value[i]) begin
        o_zeros = OUT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stage_2_pipe.sv
// ============================================================================
// Module      : stage_2_pipe
// Description : Registered interval update plus one-round renormalization with
//               valid/ready handshake; releases up to two carry-tagged bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_2_pipe
  import ec_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  UU,
  input  logic [RANGE_WIDTH-1:0]  VV,
  input  logic [RANGE_WIDTH-1:0]  lut_u,
  input  logic [RANGE_WIDTH-1:0]  lut_v,
  input  logic                    COMP_mux_1,
  input  logic                    bool,
  input  logic [SYMBOL_WIDTH-1:0] symbol,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_count,
  output logic [BYTE_WIDTH-1:0]   out_byte_0,
  output logic [BYTE_WIDTH-1:0]   out_byte_1,
  output logic [RANGE_WIDTH-1:0]  range_q,
  output logic [LOW_WIDTH-1:0]    low_q,
  output logic [D_SIZE-1:0]       s_q
);

  localparam int W1 = RANGE_WIDTH + 1;
  localparam int PW = 2 * RANGE_WIDTH;
  localparam int SW = D_SIZE + 1;

  logic [RANGE_WIDTH-1:0] r_range;
  logic [LOW_WIDTH-1:0]   r_low;
  logic [D_SIZE-1:0]      r_s;
  logic                   r_out_valid;
  emit_e                  r_out_count;
  logic [BYTE_WIDTH-1:0]  r_byte_0;
  logic [BYTE_WIDTH-1:0]  r_byte_1;

  logic                      w_accept;
  logic [RANGE_WIDTH-1:0]    w_rr;
  logic [PW-1:0]             w_prod_u;
  logic [PW-1:0]             w_prod_v;
  logic [W1-1:0]             w_u;
  logic [W1-1:0]             w_v;
  logic [W1-1:0]             w_vb;
  logic [RANGE_WIDTH-1:0]    w_range_upd;
  logic [RANGE_WIDTH-1:0]    w_low_inc;
  logic [D_SIZE-1:0]         w_d;
  logic [FULL_LOW_WIDTH-1:0] w_full_low;
  logic [FULL_LOW_WIDTH-1:0] w_mask0;
  logic [SW-1:0]             w_s_comp;
  logic [SW-1:0]             w_sh0;
  logic [RANGE_WIDTH-1:0]    w_range_nxt;
  logic [LOW_WIDTH-1:0]      w_low_nxt;
  logic [D_SIZE-1:0]         w_s_nxt;
  emit_e                     w_emit;
  logic [BYTE_WIDTH-1:0]     w_b0;
  logic [BYTE_WIDTH-1:0]     w_b1;
  logic                      w_unused_sym;

  assign in_ready     = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_unused_sym = ^symbol[SYMBOL_WIDTH-1:1];

  assign w_rr     = r_range >> 8;
  assign w_prod_u = PW'(w_rr) * PW'(UU);
  assign w_prod_v = PW'(w_rr) * PW'(VV);
  assign w_u      = W1'(w_prod_u >> 1) + W1'(lut_u);
  assign w_v      = W1'(w_prod_v >> 1) + W1'(lut_v);
  assign w_vb     = W1'(w_prod_v >> 1) + W1'(EC_MIN_PROB);

  always_comb begin
    w_range_upd = r_range;
    w_low_inc   = '0;
    if (bool) begin
      if (symbol[0]) begin
        w_low_inc   = RANGE_WIDTH'(W1'(r_range) - w_vb);
        w_range_upd = RANGE_WIDTH'(w_vb);
      end else begin
        w_range_upd = RANGE_WIDTH'(W1'(r_range) - w_vb);
      end
    end else if (COMP_mux_1) begin
      w_low_inc   = RANGE_WIDTH'(W1'(r_range) - w_u);
      w_range_upd = RANGE_WIDTH'(w_u - w_v);
    end else begin
      w_range_upd = RANGE_WIDTH'(W1'(r_range) - w_v);
    end
  end

  leading_zero #(
    .WIDTH     (RANGE_WIDTH),
    .OUT_WIDTH (D_SIZE)
  ) u_lzc (
    .i_value (w_range_upd),
    .o_zeros (w_d)
  );

  // Low is widened by a byte so the carry out of the add lands in bit 8 of byte 0
  assign w_full_low  = FULL_LOW_WIDTH'(r_low) + FULL_LOW_WIDTH'(w_low_inc);
  assign w_s_comp    = SW'(r_s) + SW'(w_d);
  assign w_sh0       = SW'(r_s) + SW'(7);
  assign w_mask0     = (FULL_LOW_WIDTH'(1) << w_sh0) - FULL_LOW_WIDTH'(1);
  assign w_range_nxt = w_range_upd << w_d;

  always_comb begin
    w_emit    = EMIT_NONE;
    w_b0      = '0;
    w_b1      = '0;
    w_low_nxt = LOW_WIDTH'(w_full_low << w_d);
    w_s_nxt   = D_SIZE'(w_s_comp);
    if (w_s_comp >= SW'(17)) begin
      w_emit    = EMIT_TWO;
      w_b0      = BYTE_WIDTH'(w_full_low >> w_sh0);
      w_b1      = BYTE_WIDTH'((w_full_low & w_mask0) >> (r_s - D_SIZE'(1)));
      w_low_nxt = LOW_WIDTH'((w_full_low & (w_mask0 >> 8)) << w_d);
      w_s_nxt   = D_SIZE'(w_s_comp - SW'(16));
    end else if (w_s_comp >= SW'(9)) begin
      w_emit    = EMIT_ONE;
      w_b0      = BYTE_WIDTH'(w_full_low >> w_sh0);
      w_low_nxt = LOW_WIDTH'((w_full_low & w_mask0) << w_d);
      w_s_nxt   = D_SIZE'(w_s_comp - SW'(8));
    end
  end

  // init outranks a handshake in the same cycle, so that symbol is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_range     <= RANGE_RESET;
      r_low       <= '0;
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= EMIT_NONE;
      r_byte_0    <= '0;
      r_byte_1    <= '0;
    end else if (init) begin
      r_range     <= RANGE_RESET;
      r_low       <= '0;
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= EMIT_NONE;
      r_byte_0    <= '0;
      r_byte_1    <= '0;
    end else if (w_accept) begin
      r_range     <= w_range_nxt;
      r_low       <= w_low_nxt;
      r_s         <= w_s_nxt;
      r_out_valid <= (w_emit != EMIT_NONE);
      r_out_count <= w_emit;
      r_byte_0    <= w_b0;
      r_byte_1    <= w_b1;
    end else if (out_ready && r_out_valid) begin
      r_out_valid <= 1'b0;
      r_out_count <= EMIT_NONE;
      r_byte_0    <= '0;
      r_byte_1    <= '0;
    end
  end

  assign range_q    = r_range;
  assign low_q      = r_low;
  assign s_q        = r_s;
  assign out_valid  = r_out_valid;
  assign out_count  = r_out_count;
  assign out_byte_0 = r_byte_0;
  assign out_byte_1 = r_byte_1;

endmodule

`default_nettype wire

// File: tb/tb_stage_2_pipe.sv
// ============================================================================
// Module      : tb_stage_2_pipe
// Description : Scoreboard bench for stage_2_pipe against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_2_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] UU, VV, lut_u, lut_v;
  logic        COMP_mux_1;
  logic        bool;
  logic [3:0]  symbol;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_count;
  logic [8:0]  out_byte_0, out_byte_1;
  logic [15:0] range_q;
  logic [23:0] low_q;
  logic [4:0]  s_q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    longint rng;
    longint low;
    longint s;
    longint cnt;
    longint b0;
    longint b1;
  } exp_t;

  exp_t   sbq[$];
  longint m_rng, m_low, m_s;

  always #5 clk = ~clk;

  stage_2_pipe #(.SYMBOL_WIDTH(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .UU         (UU),
    .VV         (VV),
    .lut_u      (lut_u),
    .lut_v      (lut_v),
    .COMP_mux_1 (COMP_mux_1),
    .bool       (bool),
    .symbol     (symbol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_byte_0 (out_byte_0),
    .out_byte_1 (out_byte_1),
    .range_q    (range_q),
    .low_q      (low_q),
    .s_q        (s_q)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input longint rng, input longint low, input longint s,
                                 input logic [15:0] uu, input logic [15:0] vv,
                                 input logic [15:0] lu, input logic [15:0] lv,
                                 input logic comp, input logic bl, input logic [3:0] sym);
    exp_t   e;
    longint rr, u, v, vb, nr, add, big, d, sc, m0;
    rr  = rng >> 8;
    u   = ((rr * uu) >> 1) + lu;
    v   = ((rr * vv) >> 1) + lv;
    vb  = ((rr * vv) >> 1) + 4;
    add = 0;
    if (bl) begin
      if (sym[0]) begin
        add = (rng - vb) & 'hFFFF;
        nr  = vb & 'hFFFF;
      end else begin
        nr  = (rng - vb) & 'hFFFF;
      end
    end else if (comp) begin
      add = (rng - u) & 'hFFFF;
      nr  = (u - v) & 'hFFFF;
    end else begin
      nr  = (rng - v) & 'hFFFF;
    end
    d = 16;
    for (int i = 15; i >= 0; i--) begin
      if (((nr >> i) & 1) != 0) begin
        d = 15 - i;
        break;
      end
    end
    big   = low + add;
    sc    = s + d;
    m0    = (longint'(1) << (s + 7)) - 1;
    e.rng = (nr << d) & 'hFFFF;
    e.b0  = 0;
    e.b1  = 0;
    if (sc < 9) begin
      e.low = (big << d) & 'hFFFFFF;
      e.s   = sc;
      e.cnt = 0;
    end else if (sc < 17) begin
      e.b0  = (big >> (s + 7)) & 'h1FF;
      e.low = ((big & m0) << d) & 'hFFFFFF;
      e.s   = s + 16 + d - 24;
      e.cnt = 1;
    end else begin
      e.b0  = (big >> (s + 7)) & 'h1FF;
      e.b1  = ((big & m0) >> (s - 1)) & 'h1FF;
      e.low = ((big & (m0 >> 8)) << d) & 'hFFFFFF;
      e.s   = s + 8 + d - 24;
      e.cnt = 2;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_rng = 'h8000;
    m_low = 0;
    m_s   = 0;
  endtask

  task automatic drive(input logic [15:0] uu, input logic [15:0] vv, input logic [15:0] lu,
                       input logic [15:0] lv, input logic comp, input logic bl,
                       input logic [3:0] sym);
    UU = uu; VV = vv; lut_u = lu; lut_v = lv;
    COMP_mux_1 = comp; bool = bl; symbol = sym;
    in_valid = 1'b1;
  endtask

  task automatic push_exp(input bit use_lit, input exp_t lit);
    exp_t e;
    e = use_lit ? lit : model(m_rng, m_low, m_s, UU, VV, lut_u, lut_v, COMP_mux_1, bool, symbol);
    m_rng = e.rng;
    m_low = e.low;
    m_s   = e.s;
    sbq.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_range"}, range_q, e.rng);
    chk({tag, "_low"},   low_q,   e.low);
    chk({tag, "_s"},     s_q,     e.s);
    chk({tag, "_cnt"},   out_count, e.cnt);
    chk({tag, "_vld"},   out_valid, (e.cnt != 0));
    if (e.cnt >= 1) chk({tag, "_b0"}, out_byte_0, e.b0);
    if (e.cnt == 2) chk({tag, "_b1"}, out_byte_1, e.b1);
  endtask

  // Inputs are already driven; waits for in_ready, scores the accepted symbol
  task automatic apply(input string tag, input logic ordy, input bit use_lit, input exp_t lit);
    int waited = 0;
    out_ready = ordy;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    push_exp(use_lit, lit);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic pulse_init();
    @(posedge clk);
    #1 init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_range"}, range_q, 16'h8000);
    chk({tag, "_low"},   low_q,   24'h0);
    chk({tag, "_s"},     s_q,     5'h0);
    chk({tag, "_vld"},   out_valid, 1'b0);
  endtask

  exp_t none_e;

  initial begin
    none_e    = '{0, 0, 0, 0, 0, 0};
    reset     = 1'b0;
    init      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    UU = '0; VV = '0; lut_u = '0; lut_v = '0;
    COMP_mux_1 = 1'b0; bool = 1'b0; symbol = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("rst");
    chk("rst_cnt", out_count, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Boolean, VV=256, symbol=1 then symbol=0 from reset
    @(posedge clk); #1;
    drive(16'd0, 16'd256, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("b256_s1", 1'b1, 1'b1, '{'h8008, 'h7FF8, 1, 0, 0, 0});
    pulse_init();
    @(negedge clk);
    chk_reset_state("init_idle");
    @(posedge clk); #1;
    drive(16'd0, 16'd256, 16'd0, 16'd0, 1'b0, 1'b1, 4'd0);
    apply("b256_s0", 1'b1, 1'b1, '{'hFFF0, 0, 2, 0, 0, 0});

    // Boolean, VV=0, symbol=1: one byte, then two bytes
    pulse_init();
    @(posedge clk); #1;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("one_byte", 1'b1, 1'b1, '{'h8000, 'hF8000, 5, 1, 'h0FF, 0});
    @(posedge clk); #1;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("two_byte", 1'b1, 1'b1, '{'h8000, 'h18000, 2, 2, 'h0FF, 'h0FF});

    // Backpressure: word held for 3 cycles, state frozen, then consume + accept together
    pulse_init();
    @(posedge clk); #1;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("bp_load", 1'b0, 1'b1, '{'h8000, 'hF8000, 5, 1, 'h0FF, 0});
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_vld", out_valid, 1'b1);
      chk("bp_b0", out_byte_0, 9'h0FF);
      chk("bp_low", low_q, 24'hF8000);
      chk("bp_s", s_q, 5'd5);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    push_exp(1'b1, '{'h8000, 'h18000, 2, 2, 'h0FF, 'h0FF});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_out("bp_accept");

    // init with a symbol present: symbol dropped, output cleared despite out_ready=0
    pulse_init();
    @(posedge clk); #1;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("pre_init", 1'b0, 1'b1, '{'h8000, 'hF8000, 5, 1, 'h0FF, 0});
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    init = 1'b1;
    @(posedge clk);
    #1 init = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_state("init_drop");

    // Asynchronous reset between edges
    @(posedge clk); #1;
    drive(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 4'd1);
    apply("pre_rst", 1'b0, 1'b1, '{'h8000, 'hF8000, 5, 1, 'h0FF, 0});
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    model_reset();

    // Random stream with occasional downstream stalls
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      drive(16'($urandom_range(0, 32767)), 16'($urandom_range(0, 32767)),
            16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)));
      apply("rand", ($urandom_range(0, 3) != 0), 1'b0, none_e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
